// File: rtl/multi_port_dist_mem.sv
// multi_port_dist_mem: one synchronous write port, NRD asynchronous read ports, zeroed by a clear sequencer after reset.
// Optional MPDM_WR_BYPASS_EN selects write-first reads; the default build is read-first.
module multi_port_dist_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic                  ready
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= CLEAR;
            cptr  <= '0;
        end else if (state == CLEAR) begin
            cptr  <= cptr + ADDR_W'(1);
            state <= &cptr ? RUN : CLEAR;
        end
    end

    assign ready = state == RUN;

    // The sequencer owns the single write port until every row is cleared.
    always_comb begin
        mem_we = rstn && (state == CLEAR || we);
        mem_a  = state == CLEAR ? cptr : wa;
        mem_d  = state == CLEAR ? '0 : wd;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] word;
        assign a = ra[k*ADDR_W +: ADDR_W];
`ifdef MPDM_WR_BYPASS_EN
        assign word = (we && a == wa) ? wd : mem[a];
`else
        assign word = mem[a];
`endif
        assign rd[k*DATA_W +: DATA_W] = ready ? word : '0;
    end
endmodule

// File: tb/tb_multi_port_dist_mem.sv
// tb_multi_port_dist_mem: random and directed stimulus checked every cycle against a behavioural memory model.
module tb_multi_port_dist_mem;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int NRD    = 2;
    localparam int DEPTH  = 64;

    logic                  clk = 0;
    logic                  rstn = 0;
    logic                  we = 0;
    logic [ADDR_W-1:0]     wa = '0;
    logic [DATA_W-1:0]     wd = '0;
    logic [NRD*ADDR_W-1:0] ra = '0;
    logic [NRD*DATA_W-1:0] rd;
    logic                  ready;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem_m [DEPTH];
    int cnt = 0;
    bit started = 0;
    bit bypass;

    multi_port_dist_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
        .clk(clk), .rstn(rstn), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd), .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
`ifdef MPDM_WR_BYPASS_EN
        bypass = 1;
`else
        bypass = 0;
`endif
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: DEPTH enabled edges after reset the whole array is known zero; writes count only once ready.
    always @(posedge clk) begin
        if (!rstn) begin
            started <= 1;
            cnt <= 0;
        end else if (started) begin
            if (cnt < DEPTH) begin
                cnt <= cnt + 1;
                if (cnt == DEPTH - 1)
                    for (int i = 0; i < DEPTH; i++) mem_m[i] <= '0;
            end else if (we) begin
                mem_m[wa] <= wd;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic rdy;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] e;
            rdy = cnt == DEPTH;
            chk("ready", {31'b0, ready}, {31'b0, rdy});
            for (int k = 0; k < NRD; k++) begin
                a = ra[k*ADDR_W +: ADDR_W];
                e = !rdy ? '0 : (bypass && we && a == wa) ? wd : mem_m[a];
                chk($sformatf("rd%0d", k), rd[k*DATA_W +: DATA_W], e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int k, input int a);
        ra[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        we = 1; wa = ADDR_W'(a); wd = d;
        step();
        we = 0;
    endtask

    initial begin
        we = 1; wa = 3; wd = 32'hFFFF_FFFF;
        repeat (3) step();
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_rd", rd[31:0], 32'd0);
        rstn = 1;
        repeat (63) step();
        chk("clear_ready_63", {31'b0, ready}, 32'd0);
        chk("clear_rd_63", rd[31:0], 32'd0);
        step();
        we = 0;
        chk("clear_ready_64", {31'b0, ready}, 32'd1);
        set_ra(0, 3);
        #1 chk("wr_during_clear", rd[31:0], 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            set_ra(0, i);
            #1 chk("sweep_zero", rd[31:0], 32'd0);
        end

        we = 1; wa = 1; wd = 32'h1111;
        step();
        wa = 2; wd = 32'h2222; set_ra(0, 1); set_ra(1, 2);
        step();
        we = 0;
        #1 chk("basic_rd0", rd[31:0], 32'h1111);
        chk("basic_rd1", rd[63:32], 32'h2222);

        wr(5, 32'hDEAD_BEEF);
        set_ra(0, 5); set_ra(1, 5);
        #1 chk("same_rd0", rd[31:0], 32'hDEAD_BEEF);
        chk("same_rd1", rd[63:32], 32'hDEAD_BEEF);

        wr(7, 32'hA);
        set_ra(0, 7); we = 1; wa = 7; wd = 32'hB;
        #1 chk("collide_pre", rd[31:0], bypass ? 32'hB : 32'hA);
        step();
        we = 0;
        #1 chk("collide_post", rd[31:0], 32'hB);

        for (int i = 0; i < 300; i++) begin
            we = $urandom_range(0, 1) == 1;
            wa = ADDR_W'($urandom);
            wd = $urandom;
            set_ra(0, $urandom_range(0, 1) == 1 ? int'(wa) : int'($urandom_range(0, DEPTH - 1)));
            set_ra(1, $urandom_range(0, DEPTH - 1));
            step();
        end
        we = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_ra(0, i); set_ra(1, DEPTH - 1 - i);
            step();
        end

        for (int i = 0; i < 4; i++) wr(i, DATA_W'(i + 1));
        set_ra(0, 2);
        #1 chk("fill_addr2", rd[31:0], 32'd3);
        rstn = 0;
        step();
        rstn = 1;
        chk("midreset_ready", {31'b0, ready}, 32'd0);
        repeat (63) step();
        chk("midreset_ready_63", {31'b0, ready}, 32'd0);
        step();
        chk("midreset_ready_64", {31'b0, ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_ra(0, i); set_ra(1, 3 - i);
            #1 chk("midreset_rd0", rd[31:0], 32'd0);
            chk("midreset_rd1", rd[63:32], 32'd0);
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
